xspi_8s_target: RTL and testbench
=================================

XSPI_8S_TARGET -- requirements
Module: xspi_8s_target

Interface
REQ-001 SHALL have parameter DUMMY_CYCLES, default 4, number of turnaround cycles between last address byte and first read data byte (range 1-15).
REQ-002 SHALL have parameter ADDR_BITS, default 4, number of low address bits indexing internal memory (depth 2**ADDR_BITS x 64 bits).
REQ-003 SHALL have port clk  input  1  single clock; also the bus clock, with one octal byte per rising edge (8S SDR).
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port cs_n  input  1  host chip select, active low.
REQ-006 SHALL have port io_in  input  8  byte driven by host.
REQ-007 SHALL have port io_out  output  8  byte driven by target; registered.
REQ-008 SHALL have port io_oe  output  1  target output enable; registered.
REQ-009 SHALL have port wr_done  output  1  one-cycle pulse on committed write.
REQ-010 SHALL have port rd_done  output  1  one-cycle pulse after last read byte.

Function
REQ-011 SHALL use states IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE; a byte is accepted only on edges where cs_n=0.
REQ-012 SHALL number transaction cycles from edge 0, the first edge with cs_n=0 in IDLE: edge 0 = command byte; edges 1-6 = address[47:0], MSB byte first.
REQ-013 SHALL decode command 8'hA5 as WRITE, 8'hFF as READ, and any other value to IGNORE until cs_n=1.
REQ-014 SHALL, for WRITE, take edges 7-14 as data[63:0], MSB byte first; commit mem[address[ADDR_BITS-1:0]] only on edge 14, with wr_done=1 during the following cycle.
REQ-015 SHALL, for READ, treat edges 7..6+DUMMY_CYCLES as dummy edges, ignoring io_in.
REQ-016 SHALL, for READ, present io_oe=1 with io_out = data byte k (MSB first) during cycle 7+DUMMY_CYCLES+k, k=0..7, where data is the memory word sampled at the end of the address phase.
REQ-017 SHALL pulse rd_done=1 for one cycle together with the last read byte (k=7).
REQ-018 SHALL, after a completed transaction, enter IGNORE: extra host bytes are discarded, io_oe=0, until cs_n=1.
REQ-019 SHALL, when cs_n=1 at any edge, return to IDLE on that edge: partial write is discarded (no memory change, no wr_done), and io_oe=0 from the next cycle.
REQ-020 SHALL accept a new transaction on the first cs_n=0 edge after any cs_n=1 edge; back-to-back transactions need exactly one cs_n=1 cycle between them.
REQ-021 SHALL keep io_oe=0 in every state except RDATA; io_out=8'h00 whenever io_oe=0.
REQ-022 SHALL ignore address bits above ADDR_BITS (aliasing/wrap-around across the 48-bit space).

Reset
REQ-023 SHALL, with rst=1 at an edge, enter IDLE and set io_out=8'h00, io_oe=0, wr_done=0, rd_done=0, all memory words=64'h0, counters=0.
REQ-024 SHALL have rst override cs_n and any in-progress transaction, including mid-read (io_oe=0 the cycle after rst) and mid-write (no commit).

Configuration
REQ-025 SHALL, with XSPI_TGT_STATUS_EN defined, decode command 8'h05 as STATUS: no address phase, no dummy; io_oe=1, io_out={1'b0, wr_count[6:0]} during edge 1's following cycle; wr_count increments (mod 128) per committed write and resets to 0.
REQ-026 SHALL, without XSPI_TGT_STATUS_EN, treat 8'h05 like any unknown command (IGNORE) and contain no wr_count logic.

Verification
REQ-027 SHALL cover write: cs_n low, A5, 66 55 44 33 22 AB, 11 22 33 44 55 66 77 88 -> mem[4'hB]=64'h1122334455667788, wr_done pulse the cycle after edge 14.
REQ-028 SHALL cover read after that write: FF, 66 55 44 33 22 AB, 4 dummies -> io_oe=1 with io_out 11,22,...,88 in cycles 11-18, rd_done in cycle 18, io_oe=0 in cycle 19.
REQ-029 SHALL cover write aborted by cs_n=1 after 4 data bytes -> mem[4'hB] unchanged, no wr_done; a subsequent read returns the old value.
REQ-030 SHALL cover unknown command 8'h3C followed by 14 bytes -> io_oe stays 0, memory unchanged, no pulses.
REQ-031 SHALL cover rst=1 asserted in cycle 13 of a read -> io_oe=0 from cycle 14, and a following read of 4'hB returns 64'h0.
REQ-032 SHALL cover, with XSPI_TGT_STATUS_EN defined, two committed writes then 05 -> io_out=8'h02 with io_oe=1.

Source files
------------

// File: rtl/xspi_8s_target.sv
// Octal SPI (8S SDR) memory target: 48-bit address, 64-bit words, one byte per clk edge.
// Optional STATUS command (8'h05 returns the committed-write count) enabled by XSPI_TGT_STATUS_EN.
module xspi_8s_target #(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter int unsigned ADDR_BITS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       io_oe,
    output logic       wr_done,
    output logic       rd_done
);

    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int unsigned CW        = 5;
    localparam int unsigned LAST_ADDR = 6;
    localparam int unsigned LAST_WR   = 14;
    localparam int unsigned FIRST_RD  = 7 + DUMMY_CYCLES;

    localparam logic [7:0] CMD_WRITE  = 8'hA5;
    localparam logic [7:0] CMD_READ   = 8'hFF;
`ifdef XSPI_TGT_STATUS_EN
    localparam logic [7:0] CMD_STATUS = 8'h05;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        DUMMY,
        RDATA,
        IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [63:0]            data_q, data_d;
    logic                   is_wr_q, is_wr_d;
    logic [2:0]             k_q, k_d;
    logic [7:0]             io_out_q, io_out_d;
    logic                   io_oe_q, io_oe_d;
    logic                   wr_done_q, wr_done_d;
    logic                   rd_done_q, rd_done_d;
    logic [63:0]            mem_q [DEPTH];
    logic                   mem_we;
    logic [63:0]            mem_wdata;
`ifdef XSPI_TGT_STATUS_EN
    logic [6:0]             wr_count_q, wr_count_d;
`endif

    // Next-state and registered-output logic; cs_n=1 aborts from any state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_wr_d   = is_wr_q;
        k_d       = k_q;
        io_out_d  = 8'h00;
        io_oe_d   = 1'b0;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = {data_q[55:0], io_in};
`ifdef XSPI_TGT_STATUS_EN
        wr_count_d = wr_count_q;
`endif
        if (cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = CW'(1);
                    if (io_in == CMD_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR;
                    end else if (io_in == CMD_READ) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR;
`ifdef XSPI_TGT_STATUS_EN
                    end else if (io_in == CMD_STATUS) begin
                        state_d = CMD;
`endif
                    end else begin
                        state_d = IGNORE;
                    end
                end
                CMD: begin
`ifdef XSPI_TGT_STATUS_EN
                    // Single status byte; k=7 makes RDATA exit on the next edge.
                    state_d  = RDATA;
                    io_oe_d  = 1'b1;
                    io_out_d = {1'b0, wr_count_q};
                    k_d      = 3'd7;
`else
                    state_d  = IGNORE;
`endif
                end
                ADDR: begin
                    addr_d = ADDR_BITS'({addr_q, io_in});
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(LAST_ADDR)) begin
                        if (is_wr_q) begin
                            state_d = WDATA;
                        end else begin
                            state_d = DUMMY;
                            data_d  = mem_q[addr_d];
                        end
                    end
                end
                WDATA: begin
                    data_d = {data_q[55:0], io_in};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(LAST_WR)) begin
                        mem_we    = 1'b1;
                        wr_done_d = 1'b1;
                        state_d   = IGNORE;
`ifdef XSPI_TGT_STATUS_EN
                        wr_count_d = wr_count_q + 7'd1;
`endif
                    end
                end
                DUMMY: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(FIRST_RD)) begin
                        state_d  = RDATA;
                        io_oe_d  = 1'b1;
                        io_out_d = data_q[63:56];
                        data_d   = {data_q[55:0], 8'h00};
                        k_d      = 3'd0;
                    end
                end
                RDATA: begin
                    if (k_q == 3'd7) begin
                        state_d = IGNORE;
                    end else begin
                        io_oe_d   = 1'b1;
                        io_out_d  = data_q[63:56];
                        data_d    = {data_q[55:0], 8'h00};
                        k_d       = k_q + 3'd1;
                        rd_done_d = (k_q == 3'd6);
                    end
                end
                default: begin
                    state_d = IGNORE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            is_wr_q   <= 1'b0;
            k_q       <= '0;
            io_out_q  <= 8'h00;
            io_oe_q   <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 64'h0;
            end
`ifdef XSPI_TGT_STATUS_EN
            wr_count_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_wr_q   <= is_wr_d;
            k_q       <= k_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            if (mem_we) begin
                mem_q[addr_q] <= mem_wdata;
            end
`ifdef XSPI_TGT_STATUS_EN
            wr_count_q <= wr_count_d;
`endif
        end
    end

    assign io_out  = io_out_q;
    assign io_oe   = io_oe_q;
    assign wr_done = wr_done_q;
    assign rd_done = rd_done_q;

endmodule

// File: tb/tb_xspi_8s_target.sv
// Directed bench for xspi_8s_target: writes, reads, aborts, unknown command, reset mid-read,
// address aliasing and (with XSPI_TGT_STATUS_EN) the STATUS command.
module tb_xspi_8s_target;

    localparam int unsigned DUMMY = 4;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic       io_oe;
    logic       wr_done;
    logic       rd_done;

    int n_checks;
    int n_pass;

    xspi_8s_target #(
        .DUMMY_CYCLES(DUMMY),
        .ADDR_BITS   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs_n   (cs_n),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe),
        .wr_done(wr_done),
        .rd_done(rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte for the next edge, then sample #1 after that edge.
    task automatic drive(input logic csn, input logic [7:0] b);
        cs_n  = csn;
        io_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [47:0] a, input logic [63:0] d, input int ndata,
                            input string tag);
        logic early;
        early = 1'b0;
        drive(1'b0, 8'hA5);
        early |= wr_done;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, a[47-8*i -: 8]);
            early |= wr_done;
        end
        for (int i = 0; i < ndata; i++) begin
            if (i == 7) begin
                check({tag, "_early_wr_done"}, 64'(early), 64'd0);
            end
            drive(1'b0, d[63-8*i -: 8]);
            if (i < 7) early |= wr_done;
        end
        if (ndata == 8) begin
            check({tag, "_wr_done"}, 64'(wr_done), 64'd1);
            drive(1'b0, 8'h99);
            check({tag, "_wr_done_one_cycle"}, 64'(wr_done), 64'd0);
            drive(1'b1, 8'h00);
        end else begin
            drive(1'b1, 8'h00);
            early |= wr_done;
            check({tag, "_abort_no_wr_done"}, 64'(early), 64'd0);
        end
    endtask

    task automatic do_read(input logic [47:0] a, input logic [63:0] exp, input string tag);
        logic [63:0] got;
        logic        oe_ok;
        logic        early_rd;
        got      = '0;
        oe_ok    = 1'b1;
        early_rd = 1'b0;
        drive(1'b0, 8'hFF);
        for (int i = 0; i < 6; i++) drive(1'b0, a[47-8*i -: 8]);
        for (int i = 0; i < int'(DUMMY); i++) drive(1'b0, 8'h5A);
        check({tag, "_oe_in_dummy"}, 64'(io_oe), 64'd0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 8'h00);
            got   = {got[55:0], io_out};
            oe_ok &= io_oe;
            if (k < 7) early_rd |= rd_done;
            else check({tag, "_rd_done"}, 64'(rd_done), 64'd1);
        end
        check({tag, "_data"}, got, exp);
        check({tag, "_oe_during_data"}, 64'(oe_ok), 64'd1);
        check({tag, "_early_rd_done"}, 64'(early_rd), 64'd0);
        drive(1'b0, 8'h00);
        check({tag, "_oe_after"}, {55'd0, io_oe, io_out}, 64'd0);
        drive(1'b1, 8'h00);
    endtask

    initial begin
        logic any_out;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        cs_n  = 1'b1;
        io_in = 8'h00;
        drive(1'b0, 8'hFF);
        drive(1'b0, 8'hFF);
        check("reset_outputs", {52'd0, io_out, io_oe, wr_done, rd_done, 1'b0}, 64'd0);
        rst = 1'b0;
        drive(1'b1, 8'h00);

        do_write(48'h66554433_22AB, 64'h1122334455667788, 8, "wr1");
        do_read (48'h66554433_22AB, 64'h1122334455667788, "rd1");

        do_write(48'h66554433_22AB, 64'hAAAABBBBCCCCDDDD, 4, "wr_abort");
        do_read (48'h66554433_22AB, 64'h1122334455667788, "rd_after_abort");

        // Unknown command followed by 14 bytes: no output, no pulses.
        any_out = 1'b0;
        drive(1'b0, 8'h3C);
        any_out |= io_oe | wr_done | rd_done;
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 8'hA5 + 8'(i));
            any_out |= io_oe | wr_done | rd_done;
        end
        check("unknown_cmd_quiet", 64'(any_out), 64'd0);
        drive(1'b1, 8'h00);
        do_read(48'h0000_0000_000B, 64'h1122334455667788, "rd_after_unknown");

        // Reset during cycle 13 of a read.
        drive(1'b0, 8'hFF);
        for (int i = 0; i < 6; i++) drive(1'b0, (i == 5) ? 8'hAB : 8'h00);
        for (int i = 0; i < int'(DUMMY); i++) drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        check("rst_mid_read_byte2", {55'd0, io_oe, io_out}, {55'd0, 1'b1, 8'h33});
        rst = 1'b1;
        drive(1'b0, 8'h00);
        check("rst_mid_read_oe", {55'd0, io_oe, io_out}, 64'd0);
        rst = 1'b0;
        drive(1'b1, 8'h00);
        do_read(48'h0000_0000_000B, 64'h0, "rd_after_rst");

        // Upper address bits alias onto the low nibble.
        do_write(48'h1234_5678_9AB3, 64'hDEADBEEFCAFEF00D, 8, "wr_alias");
        do_read (48'h0000_0000_0003, 64'hDEADBEEFCAFEF00D, "rd_alias");
        do_write(48'hFFFF_FFFF_FF0B, 64'h0102030405060708, 8, "wr2");
        do_read (48'h0000_0000_001B, 64'h0102030405060708, "rd2");

        drive(1'b0, 8'h05);
        check("status_cmd_cycle0", 64'(io_oe), 64'd0);
        drive(1'b0, 8'h00);
`ifdef XSPI_TGT_STATUS_EN
        check("status_byte", {55'd0, io_oe, io_out}, {55'd0, 1'b1, 8'h02});
        drive(1'b0, 8'h00);
        check("status_oe_after", {55'd0, io_oe, io_out}, 64'd0);
`else
        check("status_ignored", {55'd0, io_oe, io_out}, 64'd0);
`endif
        drive(1'b1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
